pipe_fetch_ctrl: RTL and testbench
==================================

// Module: pipe_fetch_ctrl
// PURPOSE
//  IF stage and IF/ID pipeline register. Consumes the ID control unit's pcsource, stall
//  (load_depen, active-low) and branch/jump targets. Fetches instructions over a req/ack
//  instruction-memory handshake and delivers them to ID with a valid flag.
//  The valid flag qualifies ID write enables. Squashes wrong-path fetches on taken
//  redirects and buffers one fetched instruction while ID is stalled.
// PARAMETERS
//  RESET_PC  32'h0000_0000  address of first fetch after reset
// PORTS
//  clock       in   1   sole clock; all state on rising edge
//  reset       in   1   asynchronous, active-high reset
//  pcsource    in   2   from ID: 00 pc+4, 01 bpc, 10 rpc (jr), 11 jpc
//  bpc         in   32  branch target
//  rpc         in   32  register target (jr)
//  jpc         in   32  jump target
//  load_depen  in   1   0 = ID stalled (hold ID), 1 = ID advances
//  imem_req    out  1   fetch request
//  imem_addr   out  32  fetch address (= pc)
//  imem_ack    in   1   1-cycle pulse: imem_rdata valid for current request
//  imem_rdata  in   32  fetched instruction
//  pc          out  32  address currently being fetched
//  id_inst     out  32  IF/ID instruction
//  id_pc4      out  32  IF/ID pc+4
//  id_valid    out  1   IF/ID holds a live instruction
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, state=S_RST, imem_req=0, id_valid=0,
//    id_inst=0, id_pc4=0, buffer empty. Any outstanding request is abandoned.
//    imem_ack in S_RST is ignored. S_RST -> S_REQ on the first clock after reset deasserts.
//  redirect = id_valid & load_depen & (pcsource!=00); target is selected by pcsource.
//    Redirects are ignored while id_valid=0.
//  Handshake: imem_req=1 in S_REQ and S_DROP. imem_addr stays stable until ack.
//    Only one request is outstanding. imem_req drops in the ack cycle only when leaving S_REQ/S_DROP.
//  S_REQ
//   - ack & redirect: discard rdata; pc<=target; id_valid<=0; stay in S_REQ.
//   - ack & load_depen: id_inst<=rdata; id_pc4<=pc+4; id_valid<=1; pc<=pc+4.
//   - ack & !load_depen: buffer<=(rdata,pc+4); pc<=pc+4; ID holds; go to S_FULL.
//   - !ack & redirect: pend<=target; id_valid<=0; go to S_DROP (addr held).
//   - !ack & load_depen: id_valid<=0 (bubble).
//   - !ack & !load_depen: ID holds.
//  S_FULL (imem_req=0)
//   - redirect: drop buffer; pc<=target; id_valid<=0; go to S_REQ.
//   - load_depen: ID<=buffer, id_valid<=1; go to S_REQ.
//   - otherwise: hold everything.
//  S_DROP: wait for ack, then discard rdata; pc<=pend; go to S_REQ. ID gets bubbles meanwhile.
//  Latency: an ack in cycle N makes id_valid=1 in N+1. The request for pc+4 issues in N+1.
//  Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. Targets are used unaligned-as-is.
//  Simultaneous: redirect has priority over buffering/advance.
//    load_depen=0 always blocks redirect (branch still in ID).
// TESTING
//  1. reset, RESET_PC=0, ack every 2nd cycle -> addrs 0,4,8 in order; id_valid pulses; id_pc4=4,8,12.
//  2. load_depen=0 for 3 cycles with ack in the first -> ID frozen; buffer holds inst@8;
//     load_depen=1 -> inst@8 in ID next cycle, then fetch 12.
//  3. beq in ID, pcsource=01, bpc=0x40, ack same cycle -> rdata dropped; id_valid=0; next addr 0x40.
//  4. jr, pcsource=10, rpc=0x100, no ack for 3 cycles -> imem_addr held at old pc until ack;
//     ack discarded; next req 0x100.
//  5. pc=32'hFFFF_FFFC, ack -> next imem_addr=0, id_pc4=0.
//  6. assert reset during S_DROP wait, stale ack in S_RST -> ignored;
//     first request addr=RESET_PC; id_valid=0.

Source files
------------

// File: rtl/pipe_fetch_ctrl.sv
`default_nettype none
// pipe_fetch_ctrl: IF stage and IF/ID register. Fetches over a req/ack imem
// handshake, squashes wrong-path fetches on redirects, skid-buffers one instruction.
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        load_depen,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] id_inst_q;
  logic [31:0] id_pc4_q;
  logic        id_valid_q;
  logic [31:0] buf_inst_q;
  logic [31:0] buf_pc4_q;
  logic [31:0] pend_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  // A stalled ID (load_depen=0) still holds the branch, so it cannot redirect yet.
  assign redirect = id_valid_q & load_depen & (pcsource != 2'b00);

  always_comb begin
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = pc_plus4;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_RST;
      pc_q       <= RESET_PC;
      id_inst_q  <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
      buf_inst_q <= 32'd0;
      buf_pc4_q  <= 32'd0;
      pend_q     <= 32'd0;
    end else begin
      case (state_q)
        S_RST: begin
          state_q    <= S_REQ;
          id_valid_q <= 1'b0;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              pc_q       <= target;
              id_valid_q <= 1'b0;
            end else if (load_depen) begin
              id_inst_q  <= imem_rdata;
              id_pc4_q   <= pc_plus4;
              id_valid_q <= 1'b1;
              pc_q       <= pc_plus4;
            end else begin
              buf_inst_q <= imem_rdata;
              buf_pc4_q  <= pc_plus4;
              pc_q       <= pc_plus4;
              state_q    <= S_FULL;
            end
          end else if (redirect) begin
            // Address must stay put until the in-flight request is acked.
            pend_q     <= target;
            id_valid_q <= 1'b0;
            state_q    <= S_DROP;
          end else if (load_depen) begin
            id_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (redirect) begin
            pc_q       <= target;
            id_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end else if (load_depen) begin
            id_inst_q  <= buf_inst_q;
            id_pc4_q   <= buf_pc4_q;
            id_valid_q <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_DROP: begin
          id_valid_q <= 1'b0;
          if (imem_ack) begin
            pc_q    <= pend_q;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_RST;
      endcase
    end
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_ctrl.sv
`default_nettype none
// tb_pipe_fetch_ctrl: directed scenarios with a scoreboard of expected IF/ID
// contents, popped whenever ID consumes a live instruction.
module tb_pipe_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, rpc = '0, jpc = '0;
  logic        load_depen = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, id_inst, id_pc4;
  logic        id_valid;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;

  pipe_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc), .load_depen(load_depen),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .id_inst(id_inst), .id_pc4(id_pc4),
    .id_valid(id_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Inputs for the coming edge are already driven; if ID advances on it, score it.
  task automatic cyc();
    logic [63:0] e;
    if (id_valid === 1'b1 && load_depen) begin
      if (exp_q.size() == 0) begin
        chk("id_valid_extra", 32'(id_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("id_inst", id_inst, e[63:32]);
        chk("id_pc4", id_pc4, e[31:0]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input int waits, input bit deliver);
    repeat (waits) begin
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, exp_pc);
      cyc();
    end
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, exp_pc);
    imem_rdata = mem(exp_pc);
    imem_ack   = 1'b1;
    if (deliver) exp_q.push_back({mem(exp_pc), exp_pc + 32'd4});
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    reset = 1'b0;
    cyc();

    // Sequential fetch, ack every 2nd cycle
    exp_pc = RESET_PC;
    fetch(1, 1'b1); exp_pc = exp_pc + 32'd4;
    fetch(1, 1'b1); exp_pc = exp_pc + 32'd4;

    // ID stall with ack in first stalled cycle: buffer inst@8
    load_depen = 1'b0;
    fetch(0, 1'b1); exp_pc = exp_pc + 32'd4;
    chk("full_req", 32'(imem_req), 32'd0);
    chk("frozen_valid", 32'(id_valid), 32'd1);
    chk("frozen_inst", id_inst, mem(32'd4));
    cyc();
    chk("full_req2", 32'(imem_req), 32'd0);
    chk("full_pc", pc, 32'd12);
    chk("frozen_inst2", id_inst, mem(32'd4));
    cyc();
    load_depen = 1'b1;
    cyc();
    chk("unbuf_inst", id_inst, mem(32'd8));
    chk("unbuf_valid", 32'(id_valid), 32'd1);

    // Taken branch with ack in the same cycle
    pcsource = 2'b01; bpc = 32'h40;
    fetch(0, 1'b0);
    pcsource = 2'b00;
    chk("br_squash", 32'(id_valid), 32'd0);
    chk("br_addr", imem_addr, 32'h40);
    exp_pc = 32'h40;
    fetch(1, 1'b1);

    // jr while request outstanding; pcsource left asserted to show it is ignored
    pcsource = 2'b10; rpc = 32'h100;
    exp_pc = 32'h44;
    fetch(3, 1'b0);
    pcsource = 2'b00;
    chk("jr_addr", imem_addr, 32'h100);
    chk("jr_squash", 32'(id_valid), 32'd0);
    exp_pc = 32'h100;
    fetch(1, 1'b1);

    // Jump to top of address space, pc+4 wraps
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    exp_pc = 32'h104;
    fetch(0, 1'b0);
    pcsource = 2'b00;
    exp_pc = 32'hFFFF_FFFC;
    fetch(1, 1'b1);
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_pc4", id_pc4, 32'd0);
    exp_pc = 32'd0;
    fetch(0, 1'b1);

    // Reset during S_DROP, stale ack while in S_RST
    pcsource = 2'b01; bpc = 32'h200;
    cyc();
    pcsource = 2'b00;
    chk("drop_addr", imem_addr, 32'd4);
    cyc();
    reset = 1'b1;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_pc", pc, RESET_PC);
    chk("ar_queue", 32'(exp_q.size()), 32'd0);
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    reset = 1'b0;
    cyc();
    imem_ack = 1'b0; imem_rdata = '0;
    chk("post_req", 32'(imem_req), 32'd1);
    chk("post_addr", imem_addr, RESET_PC);
    chk("post_valid", 32'(id_valid), 32'd0);
    cyc();
    chk("stale_valid", 32'(id_valid), 32'd0);
    exp_pc = RESET_PC;
    fetch(0, 1'b1);
    repeat (3) cyc();
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
